sseg_display_ctrl: RTL and testbench

Multi-digit seven-segment display controller for the DE2 HEX displays. Accepts a binary value on a load strobe, converts it to decimal with a sequential shift-add-3 (double-dabble) engine or passes it through as hexadecimal, and drives DIGITS active-low segment buses.

Features beyond the single-digit decoder:
- A/b/C/d/E/F glyphs in hex mode.
- Optional leading-zero blanking.
- Overflow indication.
- busy/done handshake.

---
 rtl/sseg_display_ctrl_if.sv | 24 ++
 rtl/sseg_display_ctrl.sv | 143 ++++++++++++++
 tb/tb_sseg_display_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sseg_display_ctrl_if.sv
// Load/result bundle between a host and the seven-segment display controller.
interface sseg_display_ctrl_if #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
);
  logic                  load;
  logic [WIDTH-1:0]      value;
  logic                  hex_mode;
  logic                  blank_lz;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [7*DIGITS-1:0]   seg;

  modport master (
    output load, value, hex_mode, blank_lz,
    input  busy, done, ovf, seg
  );

  modport slave (
    input  load, value, hex_mode, blank_lz,
    output busy, done, ovf, seg
  );
endinterface

// File: rtl/sseg_display_ctrl.sv
// Multi-digit seven-segment controller: binary-to-BCD by shift-add-3 or hex pass-through,
// with leading-zero blanking and overflow dashes. Segments are active low, gfedcba.
//
//   state  | meaning
//   IDLE   | waiting for load; seg/ovf hold last result
//   CONV   | one double-dabble iteration per cycle, WIDTH cycles
//   UPDATE | register seg/ovf, pulse done next cycle
module sseg_display_ctrl #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input logic                clk,
  input logic                rst,
  sseg_display_ctrl_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int EW = (WIDTH > BW) ? WIDTH : BW;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    shreg;
  logic [BW-1:0]       bcd;
  logic [BW-1:0]       bcd_adj;
  logic [CW-1:0]       cnt;
  logic                hex_q;
  logic                blz_q;
  logic                ovf_acc;
  logic [7*DIGITS-1:0] seg_q;
  logic [7*DIGITS-1:0] seg_new;
  logic                ovf_q;
  logic                ovf_new;
  logic                done_q;
  logic [EW-1:0]       ext;
  logic [BW-1:0]       dig_vec;
  logic                seen;
  logic [3:0]          nib;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0011000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.load) state_nxt = bus.hex_mode ? UPDATE : CONV;
      CONV:    if (cnt == CW'(1)) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    ext     = EW'(shreg);
    dig_vec = hex_q ? ext[BW-1:0] : bcd;
    ovf_new = hex_q ? |(ext >> BW) : ovf_acc;

    // Scan from the top so everything above the first nonzero digit can blank.
    seen    = 1'b0;
    nib     = 4'h0;
    seg_new = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = dig_vec[4*i +: 4];
      if (nib != 4'h0 || i == 0) seen = 1'b1;
      if (ovf_new)             seg_new[7*i +: 7] = 7'b0111111;
      else if (blz_q && !seen) seg_new[7*i +: 7] = 7'b1111111;
      else                     seg_new[7*i +: 7] = glyph(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bcd     <= '0;
      cnt     <= '0;
      hex_q   <= 1'b0;
      blz_q   <= 1'b0;
      ovf_acc <= 1'b0;
      seg_q   <= '1;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            shreg   <= bus.value;
            hex_q   <= bus.hex_mode;
            blz_q   <= bus.blank_lz;
            bcd     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CW'(WIDTH);
          end
        end
        CONV: begin
          bcd     <= {bcd_adj[BW-2:0], shreg[WIDTH-1]};
          shreg   <= shreg << 1;
          ovf_acc <= ovf_acc | bcd_adj[BW-1];
          cnt     <= cnt - CW'(1);
        end
        UPDATE: begin
          seg_q  <= seg_new;
          ovf_q  <= ovf_new;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.seg  = seg_q;
endmodule

// File: tb/tb_sseg_display_ctrl.sv
// Directed and randomized checks of sseg_display_ctrl against an arithmetic digit model.
module tb_sseg_display_ctrl;
  localparam int DIGITS = 4;
  localparam int WIDTH  = 14;
  localparam int SW     = 7 * DIGITS;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [SW-1:0] last_seg;
  logic [SW-1:0] exp_seg;
  bit            exp_ovf;

  sseg_display_ctrl_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

  sseg_display_ctrl #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] gl(input int n);
    case (n)
      0: gl = 7'b1000000;  1: gl = 7'b1111001;  2: gl = 7'b0100100;  3: gl = 7'b0110000;
      4: gl = 7'b0011001;  5: gl = 7'b0010010;  6: gl = 7'b0000010;  7: gl = 7'b1111000;
      8: gl = 7'b0000000;  9: gl = 7'b0011000; 10: gl = 7'b0001000; 11: gl = 7'b0000011;
      12: gl = 7'b1000110; 13: gl = 7'b0100001; 14: gl = 7'b0000110; default: gl = 7'b0001110;
    endcase
  endfunction

  // Digits by repeated division, overflow by comparison with base**DIGITS.
  function automatic logic [SW-1:0] model(input longint v, input bit h, input bit b, output bit o);
    longint base = h ? 16 : 10;
    longint lim  = 1;
    longint rem;
    int     d[DIGITS];
    int     msd = 0;
    logic [SW-1:0] r;
    for (int i = 0; i < DIGITS; i++) lim = lim * base;
    o   = (v >= lim);
    rem = v;
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = int'(rem % base);
      rem  = rem / base;
      if (d[i] != 0) msd = i;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (o)                r[7*i +: 7] = 7'b0111111;
      else if (b && i > msd) r[7*i +: 7] = 7'b1111111;
      else                  r[7*i +: 7] = gl(d[i]);
    end
    return r;
  endfunction

  // Drives load across one rising edge (edge 0); scrambles inputs afterwards.
  task automatic start(input int v, input bit h, input bit b);
    @(negedge clk);
    bus.load     = 1'b1;
    bus.value    = WIDTH'(v);
    bus.hex_mode = h;
    bus.blank_lz = b;
    @(posedge clk); #1;
    check("busy_edge0", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.load     = 1'b0;
    bus.value    = WIDTH'($urandom);
    bus.hex_mode = 1'($urandom);
    bus.blank_lz = 1'($urandom);
  endtask

  // Waits for done starting after edge 'from'; checks latency, hold of old outputs and result.
  task automatic finish_op(input string tag, input int from, input int exp_edge,
                           input logic [SW-1:0] es, input bit eo);
    int k;
    int busy_bad = 0;
    int seg_bad  = 0;
    for (k = from + 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) break;
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.seg !== last_seg) seg_bad++;
    end
    check({tag, "_latency"}, 64'(k), 64'(exp_edge));
    check({tag, "_busy_held"}, 64'(busy_bad), 64'd0);
    check({tag, "_seg_held"}, 64'(seg_bad), 64'd0);
    check({tag, "_seg"}, 64'(bus.seg), 64'(es));
    check({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
    check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
    last_seg = es;
  endtask

  task automatic done_drops(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int dcount;
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.hex_mode = 1'b0;
    bus.blank_lz = 1'b0;
    last_seg     = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", 64'(bus.seg), 64'(28'hFFFFFFF));
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    start(1234, 1'b0, 1'b0);
    finish_op("dec1234", 0, WIDTH + 1, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 1'b0);
    done_drops("dec1234");

    start(7, 1'b0, 1'b1);
    finish_op("dec7_blz", 0, WIDTH + 1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000}, 1'b0);
    start(0, 1'b0, 1'b1);
    finish_op("dec0_blz", 0, WIDTH + 1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 1'b0);

    start(10000, 1'b0, 1'b0);
    finish_op("dec10000", 0, WIDTH + 1, {4{7'b0111111}}, 1'b1);
    start(9999, 1'b0, 1'b1);
    finish_op("dec9999", 0, WIDTH + 1, {4{7'b0011000}}, 1'b0);

    start(14'h2BCD, 1'b1, 1'b0);
    finish_op("hex2BCD", 0, 1, {7'b0100100, 7'b0000011, 7'b1000110, 7'b0100001}, 1'b0);
    done_drops("hex2BCD");
    start(14'h0A0, 1'b1, 1'b1);
    finish_op("hexA0_blz", 0, 1, {7'b1111111, 7'b1111111, 7'b0001000, 7'b1000000}, 1'b0);

    // Second load during conversion is dropped; a load in the done cycle is taken.
    start(1234, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.load  = 1'b1;
    bus.value = WIDTH'(5678);
    @(posedge clk); #1;
    @(negedge clk);
    bus.load  = 1'b0;
    finish_op("ignore", 5, WIDTH + 1, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 1'b0);
    start(5678, 1'b0, 1'b0);
    finish_op("done_cycle_load", 0, WIDTH + 1, {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 1'b0);
    done_drops("done_cycle_load");

    // Reset at edge 8 with ovf still set from a prior result.
    start(10000, 1'b0, 1'b0);
    finish_op("pre_rst_ovf", 0, WIDTH + 1, {4{7'b0111111}}, 1'b1);
    start(1234, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_seg", 64'(bus.seg), 64'(28'hFFFFFFF));
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    last_seg = '1;
    dcount = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dcount++;
    end
    check("midrst_no_done", 64'(dcount), 64'd0);
    start(42, 1'b0, 1'b1);
    finish_op("after_rst42", 0, WIDTH + 1, {7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100}, 1'b0);

    for (int n = 0; n < 30; n++) begin
      int v;
      bit h, b;
      v = int'($urandom_range(0, (1 << WIDTH) - 1));
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 300));
      h = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      exp_seg = model(longint'(v), h, b, exp_ovf);
      start(v, h, b);
      finish_op($sformatf("rnd%0d", n), 0, h ? 1 : WIDTH + 1, exp_seg, exp_ovf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
